reg_file_reader: RTL

REG_FILE_READER -- requirements
Module: reg_file_reader

---
 rtl/reg_file_reader_if.sv | 25 ++
 rtl/reg_file_reader.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/reg_file_reader_if.sv
// rtl/reg_file_reader_if.sv - control, register-file read and output-stream signals of reg_file_reader
interface reg_file_reader_if;
  logic       start;
  logic [1:0] first_addr;
  logic [1:0] last_addr;
  logic [1:0] r_addr;
  logic [7:0] r_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_addr;
  logic       out_last;
  logic       busy;
  logic       done;

  modport master (
    input  start, first_addr, last_addr, r_data, out_ready,
    output r_addr, out_valid, out_data, out_addr, out_last, busy, done
  );

  modport slave (
    output start, first_addr, last_addr, r_data, out_ready,
    input  r_addr, out_valid, out_data, out_addr, out_last, busy, done
  );
endinterface

// File: rtl/reg_file_reader.sv
// rtl/reg_file_reader.sv - streams a wrapping range of a 4x8 register file, one beat per fetch
// Optional trailing XOR checksum beat when READER_CHECKSUM_EN is defined.
module reg_file_reader (
  input logic               clk,
  input logic               rst,
  reg_file_reader_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
`ifdef READER_CHECKSUM_EN
  localparam logic [1:0] ST_CSUM  = 2'd3;
`endif

  logic [1:0] state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [1:0] r_addr_q, r_addr_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic [1:0] out_addr_q, out_addr_d;
  logic       out_last_q, out_last_d;
  logic       done_q, done_d;
`ifdef READER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  logic beat_accept;
  assign beat_accept = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    r_addr_d    = r_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
`ifdef READER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          last_d   = bus.last_addr;
          r_addr_d = bus.first_addr;
          state_d  = ST_FETCH;
`ifdef READER_CHECKSUM_EN
          csum_d   = 8'd0;
`endif
        end
      end

      ST_FETCH: begin
        out_data_d  = bus.r_data;
        out_addr_d  = r_addr_q;
        out_valid_d = 1'b1;
`ifdef READER_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = (r_addr_q == last_q);
`endif
        state_d     = ST_SEND;
      end

      ST_SEND: begin
        if (beat_accept) begin
          out_valid_d = 1'b0;
`ifdef READER_CHECKSUM_EN
          csum_d      = csum_q ^ out_data_q;
`endif
          if (r_addr_q != last_q) begin
            r_addr_d = r_addr_q + 2'd1;
            state_d  = ST_FETCH;
          end else begin
`ifdef READER_CHECKSUM_EN
            // Fold the final data beat in directly so the checksum beat is ready next cycle.
            out_valid_d = 1'b1;
            out_data_d  = csum_q ^ out_data_q;
            out_addr_d  = 2'd0;
            out_last_d  = 1'b1;
            state_d     = ST_CSUM;
`else
            done_d      = 1'b1;
            state_d     = ST_IDLE;
`endif
          end
        end
      end

`ifdef READER_CHECKSUM_EN
      ST_CSUM: begin
        if (beat_accept) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 2'd0;
      r_addr_q    <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_addr_q  <= 2'd0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef READER_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      r_addr_q    <= r_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
`ifdef READER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.r_addr    = r_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;

endmodule
